// File: rtl/tile_addr_sequencer_if.sv
// tile_addr_sequencer_if: valid/ready address stream toward the layer-IO memory read port.
interface tile_addr_sequencer_if #(
  parameter int ADDR_W = 24
);
  logic              valid;
  logic              ready;
  logic              last;
  logic [ADDR_W-1:0] addr;
  modport master(output valid, addr, last, input ready);
  modport slave(input valid, addr, last, output ready);
endinterface

// File: rtl/tile_addr_sequencer.sv
// tile_addr_sequencer: credit-gated counter advances feeding a show-ahead address buffer,
// with a cross-check of the transfer length against the counter's all-digits-last flag.
module tile_addr_sequencer #(
  parameter int ADDR_W      = 24,
  parameter int LEN_W       = 24,
  parameter int CNT_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_start,
  input  logic [LEN_W-1:0]     i_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cnt_en,
  output logic                 o_cnt_stride_valid,
  input  logic [ADDR_W-1:0]    i_cnt_totalcount,
  input  logic                 i_cnt_all_last,
  output logic                 o_err_last_mismatch,
  tile_addr_sequencer_if.master o_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW:0] DEP = (OW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                 r_state;
  logic [LEN_W-1:0]       r_len, r_issued;
  logic [CNT_LATENCY-1:0] r_vld, r_fin;
  logic [ADDR_W-1:0]      r_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  r_last;
  logic [PW-1:0]          r_wp, r_rp;
  logic [OW-1:0]          r_occ, r_infl;
  logic                   r_done, r_sv, r_err;
  logic                   w_start, w_fin, w_push, w_pop;
  assign w_start = i_start && r_state == IDLE;
  assign w_fin   = r_issued == r_len - LEN_W'(1);
  assign w_push  = r_vld[CNT_LATENCY-1];
  assign w_pop   = o_out.valid && o_out.ready;
  // credit uses only registered occupancy/inflight, so out_ready never reaches cnt_en
  assign o_cnt_en = r_state == RUN && r_issued < r_len && ({1'b0, r_occ} + {1'b0, r_infl} < DEP);
  assign o_busy              = r_state != IDLE;
  assign o_done              = r_done;
  assign o_cnt_stride_valid  = r_sv;
  assign o_err_last_mismatch = r_err;
  assign o_out.valid = r_occ != '0;
  assign o_out.addr  = r_addr[r_rp];
  assign o_out.last  = o_out.valid && r_last[r_rp];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_issued <= '0;
      r_vld    <= '0;
      r_fin    <= '0;
      r_last   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_occ    <= '0;
      r_infl   <= '0;
      r_done   <= 1'b0;
      r_sv     <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_addr[i] <= '0;
    end else begin
      r_done <= (w_start && i_len == '0) || (w_pop && o_out.last);
      r_sv   <= w_start && i_len != '0;
      if (w_start) r_err <= 1'b0;
      if (w_push && r_fin[CNT_LATENCY-1] != i_cnt_all_last) r_err <= 1'b1;
      r_vld  <= (r_vld << 1) | CNT_LATENCY'(o_cnt_en);
      r_fin  <= (r_fin << 1) | CNT_LATENCY'(o_cnt_en && w_fin);
      r_infl <= r_infl + OW'(o_cnt_en) - OW'(w_push);
      r_occ  <= r_occ + OW'(w_push) - OW'(w_pop);
      if (w_push) begin
        r_addr[r_wp] <= i_cnt_totalcount;
        r_last[r_wp] <= r_fin[CNT_LATENCY-1];
        r_wp         <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      if (o_cnt_en) r_issued <= r_issued + LEN_W'(1);
      case (r_state)
        IDLE:    if (w_start && i_len != '0) begin
                   r_len    <= i_len;
                   r_issued <= '0;
                   r_state  <= RUN;
                 end
        RUN:     if (o_cnt_en && w_fin) r_state <= DRAIN;
        DRAIN:   if (w_pop && o_out.last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tile_addr_sequencer.sv
// tb_tile_addr_sequencer: two sequencers (counter latency 1 and 3) driven by a behavioural
// counter model; a scoreboard derives every expected address as offset + index*stride.
module tb_tile_addr_sequencer;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]  start = '0, ready = '0, early = '0;
  logic [23:0] len_i [2] = '{default: '0};
  logic [23:0] off [2] = '{default: '0};
  logic [23:0] stride [2] = '{default: '0};
  int          xlen [2] = '{default: 0};
  logic [1:0]  busy, done, en, sv, valid, last, err;
  logic [23:0] addr [2];
  int          n [2] = '{default: 0};
  int          lasts [2] = '{default: 0};
  int          ens [2] = '{default: 0};
  int          errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_addr(input int g);
    return off[g] + 24'(n[g]) * stride[g];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = g == 0 ? 1 : 3;
    tile_addr_sequencer_if #(.ADDR_W(24)) bus ();
    logic [23:0] pa [3];
    logic [2:0]  pl;
    logic [23:0] k, kk;
    assign kk = sv[g] ? '0 : k;
    tile_addr_sequencer #(.ADDR_W(24), .LEN_W(24), .CNT_LATENCY(L), .FIFO_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .i_start(start[g]), .i_len(len_i[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_cnt_en(en[g]), .o_cnt_stride_valid(sv[g]),
      .i_cnt_totalcount(pa[L-1]), .i_cnt_all_last(pl[L-1]),
      .o_err_last_mismatch(err[g]), .o_out(bus));
    assign bus.ready = ready[g];
    assign valid[g]  = bus.valid;
    assign addr[g]   = bus.addr;
    assign last[g]   = bus.last;
    // counter model: value for the k-th advance appears L cycles later; garbage otherwise
    always @(posedge clk or negedge resetn)
      if (!resetn) begin
        k  <= '0;
        pl <= '0;
        for (int i = 0; i < 3; i++) pa[i] <= '0;
      end else begin
        k     <= kk + 24'(en[g]);
        pa[0] <= en[g] ? off[g] + kk * stride[g] : 24'($urandom);
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pl    <= {pl[1:0], en[g] && 32'(kk) == xlen[g] - 1 - int'(early[g])};
      end
  end

  // scoreboard: in-order addresses, last only on the final one, credit never exceeded
  always @(negedge clk)
    if (resetn)
      for (int g = 0; g < 2; g++) begin
        if (en[g]) chk("credit", 32'((sv[g] ? 0 : ens[g]) - n[g] < 4), 1);
        ens[g] <= (sv[g] ? 0 : ens[g]) + int'(en[g]);
        if (sv[g]) begin
          n[g]     <= 0;
          lasts[g] <= 0;
        end else if (valid[g] && ready[g]) begin
          chk("pop_in_range", 32'(n[g] < xlen[g]), 1);
          chk("addr", 32'(addr[g]), 32'(exp_addr(g)));
          chk("last", 32'(last[g]), 32'(n[g] == xlen[g] - 1));
          n[g]     <= n[g] + 1;
          lasts[g] <= lasts[g] + int'(last[g]);
        end
      end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int g, input int l, input logic [23:0] o, input logic [23:0] s);
    off[g]    = o;
    stride[g] = s;
    xlen[g]   = l;
    len_i[g]  = 24'(l);
    start[g]  = 1'b1;
    tick();
    start[g]  = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input bit rnd);
    int c = 0;
    while (!done[g] && c < budget) begin
      if (rnd) ready[g] = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    chk("done_seen", 32'(done[g]), 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_sv", 32'(sv), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(addr[0]), 0);
    resetn = 1'b1;
    tick();

    ready[0] = 1'b1;
    go(0, 8, 24'h100, 24'h1);
    chk("t1_sv", 32'(sv[0]), 1);
    chk("t1_en", 32'(en[0]), 1);
    chk("t1_busy", 32'(busy[0]), 1);
    tick();
    chk("t1_not_yet_valid", 32'(valid[0]), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", 32'(valid[0]), 1);
      chk("t1_addr", 32'(addr[0]), 32'h100 + i);
      chk("t1_last", 32'(last[0]), 32'(i == 7));
      tick();
    end
    chk("t1_done", 32'(done[0]), 1);
    chk("t1_idle", 32'(busy[0]), 0);
    chk("t1_empty", 32'(valid[0]), 0);
    chk("t1_err", 32'(err[0]), 0);
    tick();
    chk("t1_done_pulse", 32'(done[0]), 0);

    go(0, 0, 24'h0, 24'h0);
    chk("z_done", 32'(done[0]), 1);
    chk("z_sv", 32'(sv[0]), 0);
    chk("z_busy", 32'(busy[0]), 0);
    for (int i = 0; i < 4; i++) begin
      chk("z_en", 32'(en[0]), 0);
      chk("z_valid", 32'(valid[0]), 0);
      tick();
      chk("z_done_once", 32'(done[0]), 0);
    end

    go(0, 20, 24'($urandom), 24'($urandom_range(1, 255)));
    repeat (4) tick();
    ready[0] = 1'b0;
    repeat (10) tick();
    chk("bp_en_stalled", 32'(en[0]), 0);
    chk("bp_valid", 32'(valid[0]), 1);
    ready[0] = 1'b1;
    wait_done(0, 100, 1'b0);
    chk("bp_count", 32'(n[0]), 20);
    chk("bp_lasts", 32'(lasts[0]), 1);
    chk("bp_ens", 32'(ens[0]), 20);
    chk("bp_err", 32'(err[0]), 0);

    early[0] = 1'b1;
    go(0, 6, 24'h40, 24'h4);
    wait_done(0, 50, 1'b0);
    chk("el_err", 32'(err[0]), 1);
    repeat (3) tick();
    chk("el_err_sticky", 32'(err[0]), 1);
    early[0] = 1'b0;
    go(0, 3, 24'h80, 24'h2);
    chk("el_err_clear", 32'(err[0]), 0);
    wait_done(0, 50, 1'b0);
    chk("el_err_clean", 32'(err[0]), 0);
    chk("el_count", 32'(n[0]), 3);

    go(0, 10, 24'h200, 24'h10);
    tick();
    len_i[0] = 24'd3;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("ign_sv", 32'(sv[0]), 0);
    chk("ign_busy", 32'(busy[0]), 1);
    wait_done(0, 50, 1'b0);
    chk("ign_count", 32'(n[0]), 10);
    chk("ign_lasts", 32'(lasts[0]), 1);

    ready[0] = 1'b0;
    go(0, 3, 24'h300, 24'h1);
    repeat (4) tick();
    chk("rd_busy", 32'(busy[0]), 1);
    chk("rd_valid", 32'(valid[0]), 1);
    chk("rd_en_drain", 32'(en[0]), 0);
    #2 resetn = 1'b0;
    #1;
    chk("rd_rst_busy", 32'(busy[0]), 0);
    chk("rd_rst_valid", 32'(valid[0]), 0);
    chk("rd_rst_last", 32'(last[0]), 0);
    chk("rd_rst_addr", 32'(addr[0]), 0);
    chk("rd_rst_done", 32'(done[0]), 0);
    chk("rd_rst_en", 32'(en[0]), 0);
    tick();
    resetn   = 1'b1;
    ready[0] = 1'b1;
    tick();
    go(0, 5, 24'h500, 24'h3);
    wait_done(0, 50, 1'b0);
    chk("rd_count", 32'(n[0]), 5);
    chk("rd_lasts", 32'(lasts[0]), 1);
    chk("rd_err", 32'(err[0]), 0);

    go(1, 1000, 24'($urandom), 24'($urandom_range(1, 1000)));
    wait_done(1, 20000, 1'b1);
    chk("big_count", 32'(n[1]), 1000);
    chk("big_lasts", 32'(lasts[1]), 1);
    chk("big_ens", 32'(ens[1]), 1000);
    chk("big_err", 32'(err[1]), 0);
    tick();
    chk("big_idle", 32'(busy[1]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
